// File: rtl/fft_seq_pkg.sv
// fft_seq_pkg: shared state encoding, framing constants and frame-length legality check
package fft_seq_pkg;

    typedef enum logic [1:0] {IDLE, STREAM, PAD} seq_state_t;

    localparam int MIN_PTS = 8;
    localparam logic [1:0] ERR_MISSING = 2'b01;

    function automatic logic pts_legal(input int unsigned pts, input int unsigned max_pts);
        return pts >= MIN_PTS && pts <= max_pts && (pts & (pts - 1)) == 0;
    endfunction

endpackage

// File: rtl/seq_fifo.sv
// seq_fifo: show-ahead synchronous FIFO; the head word is registered, so a write
// into an empty FIFO is visible on dout the following cycle
module seq_fifo #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic              empty,
    output logic [AW:0]       level
);
    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr, rd_next;
    logic wr_en, rd_en;

    assign full    = level == (AW+1)'(DEPTH);
    assign empty   = level == '0;
    assign wr_en   = push && !full;
    assign rd_en   = pop && !empty;
    assign rd_next = rd_ptr + AW'(rd_en);

    always_ff @(posedge clk)
        if (wr_en) mem[wr_ptr] <= din;

    // the new head comes straight from din when the FIFO drains to the word being written
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            dout   <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(wr_en);
            rd_ptr <= rd_next;
            level  <= level + (AW+1)'(wr_en) - (AW+1)'(rd_en);
            dout   <= (wr_en && wr_ptr == rd_next) ? din : mem[rd_next];
        end
    end

endmodule

// File: rtl/fft_frame_sequencer.sv
// fft_frame_sequencer: frames a stalling-free sample stream into sop/eop packets for the FFT core.
// Optional FFT_SEQ_ZERO_PAD_EN: flush closes an open frame by draining then padding with zeros.
module fft_frame_sequencer
    import fft_seq_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int MAX_PTS    = 512,
    parameter int FIFO_DEPTH = 16,
    parameter int PTS_W      = 10
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          in_valid,
    input  logic [DATA_W-1:0]             in_data,
    input  logic                          flush,
    input  logic [PTS_W-1:0]              fftpts_in,
    input  logic                          out_ready,
    output logic                          out_valid,
    output logic                          out_sop,
    output logic                          out_eop,
    output logic [DATA_W-1:0]             out_real,
    output logic [DATA_W-1:0]             out_imag,
    output logic [1:0]                    out_error,
    output logic                          overflow,
    output logic                          cfg_err,
    output logic [15:0]                   frame_cnt,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    seq_state_t state;
    logic [PTS_W-1:0] idx, n;
    logic [DATA_W-1:0] head;
    logic full, empty, xfer, last, bad, pts_ok;

    assign out_valid = state == PAD || !empty;
    assign last      = idx == n - 1'b1;
    assign out_sop   = out_valid && idx == '0;
    assign out_eop   = out_valid && last;
    assign out_real  = (state == PAD || empty) ? '0 : head;
    assign out_imag  = '0;
    assign out_error = (out_eop && bad) ? ERR_MISSING : 2'b00;
    assign xfer      = out_valid && out_ready;
    assign pts_ok    = pts_legal(32'(fftpts_in), MAX_PTS);

    seq_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (in_valid),
        .pop     (xfer && state != PAD),
        .din     (in_data),
        .dout    (head),
        .full    (full),
        .empty   (empty),
        .level   (fifo_level)
    );

`ifdef FFT_SEQ_ZERO_PAD_EN
    logic pend;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) pend <= 1'b0;
        else          pend <= !(xfer && last) && (pend || (flush && idx != '0));
    end
`else
    logic unused_flush;
    assign unused_flush = flush;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            idx       <= '0;
            n         <= PTS_W'(MAX_PTS);
            bad       <= 1'b0;
            overflow  <= 1'b0;
            cfg_err   <= 1'b0;
            frame_cnt <= '0;
        end else begin
            overflow <= in_valid && full;
            // a drop in the same cycle as eop is charged to the following frame
            bad      <= (in_valid && full) || (bad && !(xfer && last));
            if (xfer && out_sop) begin
                n       <= pts_ok ? fftpts_in : PTS_W'(MAX_PTS);
                cfg_err <= cfg_err | !pts_ok;
            end
            if (xfer) idx <= last ? '0 : idx + 1'b1;
            if (xfer && last) frame_cnt <= frame_cnt + 1'b1;
            case (state)
                IDLE:   if (!empty) state <= STREAM;
                STREAM:
`ifdef FFT_SEQ_ZERO_PAD_EN
                    if (pend && empty && idx != '0) state <= PAD; else
`endif
                    if (empty && idx == '0) state <= IDLE;
                PAD:    if (xfer && last) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/fft_frame_sequencer.md
Name: fft_frame_sequencer

Overview:
- Parametrised front end that turns a continuous audio sample stream into framed packets for the streaming FFT/IFFT core.
- Buffers samples in an internal FIFO and honours the core's backpressure, which the first-generation counter wrapper did not.
- Generates sop/eop for a frame length selectable at run time and reports overflow and configuration errors.
- Sits between the audio capture path and the in_fft sink interface; one instance per channel.

Parameters:
DATA_W, 16, sample and output data width in bits
MAX_PTS, 512, largest supported frame length; power of two, minimum 8
FIFO_DEPTH, 16, sample FIFO entries; power of two, minimum 2
PTS_W, 10, width of the frame-length port; equals log2(MAX_PTS)+1

Ports:
clk  in  1  single system clock, rising edge
reset_n  in  1  asynchronous active-low reset
in_valid  in  1  sample strobe; the audio source cannot stall
in_data  in  DATA_W  signed sample
flush  in  1  single-cycle request to close the current frame
fftpts_in  in  PTS_W  requested frame length; sampled at each frame start
out_ready  in  1  core sink_ready
out_valid  out  1  core sink_valid
out_sop  out  1  first sample of a frame
out_eop  out  1  last sample of a frame
out_real  out  DATA_W  sample to the core
out_imag  out  DATA_W  constant zero
out_error  out  2  core sink_error; 2'b01 means the frame lost samples, otherwise 2'b00
overflow  out  1  one-cycle pulse per dropped sample
cfg_err  out  1  sticky flag: an illegal fftpts_in was seen; cleared only by reset
frame_cnt  out  16  count of completed frames, wraps at 65535
fifo_level  out  log2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (asynchronous, any time, including mid-frame): FIFO empty, sample index 0, state IDLE, every output 0, latched length = MAX_PTS.
- FIFO write: a sample is written when in_valid=1 and the FIFO is not full.
- Overflow: when in_valid=1 and the FIFO is full, the sample is dropped, even if a read happens in the same cycle. overflow pulses on the next cycle. The current frame is marked bad.
- FIFO output: show-ahead, registered. A sample written in cycle t is presentable at out_real in cycle t+1 at the earliest.
- Transfer: occurs when out_valid=1 and out_ready=1. While out_ready=0, out_valid, out_real, out_sop and out_eop hold stable.
- Sample index: increments on each transfer.
  - out_sop = (index==0).
  - out_eop = (index==N-1), then index wraps to 0 and frame_cnt increments.
- Frame length latch: N is latched from fftpts_in on the transfer that carries out_sop.
- Legal N: a power of two with 8 <= N <= MAX_PTS. Any other value latches MAX_PTS and sets cfg_err.
- Bad frames: if the frame is marked bad, out_error=2'b01 on that frame's eop beat. The mark clears after eop.
- States:
  - IDLE (index 0, FIFO empty) -> STREAM on the first sample.
  - STREAM -> IDLE after an eop when the FIFO is empty.
  - STREAM -> PAD only under the optional feature.
- Simultaneous empty-read-write: out_valid rises the next cycle; no bypass path.
- Full plus read: occupancy decreases by 1; the write is rejected.

Optional Feature:
FFT_SEQ_ZERO_PAD_EN
- Defined:
  - A flush arriving while index != 0 makes the block first drain the FIFO within the frame.
  - If the frame is still open after the drain, the block enters PAD and emits zero samples with out_valid=1, under normal backpressure, until eop.
  - It then returns to IDLE. Input samples arriving during PAD are buffered and start the next frame.
  - A flush with index == 0 is ignored.
- Undefined: flush is ignored and frames complete only with real samples.

Decomposition:
- Shared package fft_seq_pkg holds:
  - the state enum (IDLE, STREAM, PAD);
  - the constants MIN_PTS=8 and ERR_MISSING=2'b01;
  - a function that checks whether a length is legal.
- Sub-module seq_fifo: a parametrised show-ahead synchronous FIFO with full, empty and level outputs. The frame counter and state machine stay in the top module.

Test Plan:
1. fftpts_in=8, continuous in_valid, out_ready=1:
   - sop on samples 0, 8, 16; eop on 7, 15, 23;
   - frame_cnt=3 after 24 samples; first out_valid one cycle after the first in_valid.
2. out_ready low for 20 cycles with FIFO_DEPTH=16 and continuous input:
   - fifo_level saturates at 16 and 4 overflow pulses occur;
   - that frame's eop carries out_error=2'b01; the next frame carries 2'b00.
3. fftpts_in=12, then 0:
   - cfg_err=1 and the frame is 512 samples long;
   - cfg_err stays set until reset.
4. fftpts_in changed from 8 to 16 mid-frame:
   - the current frame still ends after 8 samples; the next frame is 16 samples long.
5. Reset asserted mid-frame at index 5:
   - all outputs 0 immediately; after release, the first sample carries sop.
6. With FFT_SEQ_ZERO_PAD_EN, N=16, 5 samples then flush:
   - 11 zero samples follow, the last one with eop, and frame_cnt increments.
   - Without the macro, no beats follow until more input arrives.
